// File: rtl/tl_defs.sv
// rtl/tl_defs.sv - shared phase encodings, lamp codes and lamp decode for the traffic-light controller
package tl_defs;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // A green
    S1 = 3'd1,  // A yellow after green
    S2 = 3'd2,  // A left
    S3 = 3'd3,  // A yellow after left
    S4 = 3'd4,  // B green
    S5 = 3'd5,  // B yellow after green
    S6 = 3'd6,  // B left
    S7 = 3'd7   // B yellow after left
  } phase_t;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    LEFT   = 2'd2,
    RED    = 2'd3
  } lamp_t;

  typedef struct packed {
    lamp_t la;
    lamp_t lb;
  } lamps_t;

  // Road A owns S0..S3, road B owns S4..S7; the idle road is always red.
  function automatic lamps_t lamp_decode(input phase_t s);
    lamps_t l;
    l.la = RED;
    l.lb = RED;
    case (s)
      S0:      l.la = GREEN;
      S1, S3:  l.la = YELLOW;
      S2:      l.la = LEFT;
      S4:      l.lb = GREEN;
      S5, S7:  l.lb = YELLOW;
      S6:      l.lb = LEFT;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// rtl/tl_phase_timer.sv - per-phase dwell counter with clear and enable
module tl_phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  output logic [TW-1:0] tmr
);

  // Count enabled cycles in the current phase; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmr <= '0;
    end else if (en) begin
      if (clr) tmr <= '0;
      else     tmr <= tmr + 1'b1;
    end
  end

endmodule

// File: rtl/tl_cntr_timed.sv
// rtl/tl_cntr_timed.sv - timed eight-phase traffic-light controller with protected left turns
module tl_cntr_timed
  import tl_defs::*;
#(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 10,
  parameter int YELLOW_TIME = 2,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [2:0] q,
  output logic       phase_start
);

  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_TIME - 1);

  phase_t        state;
  phase_t        nxt;
  logic [TW-1:0] tmr;
  logic          sensor;
  logic          is_green;
  logic          phase_exit;
  lamps_t        lamps;

  tl_phase_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clr     (phase_exit),
    .tmr     (tmr)
  );

  // Pick the demand sensor that can extend the current green/left phase.
  always_comb begin
    sensor   = 1'b0;
    is_green = 1'b0;
    case (state)
      S0: begin sensor = Ta;  is_green = 1'b1; end
      S2: begin sensor = Tal; is_green = 1'b1; end
      S4: begin sensor = Tb;  is_green = 1'b1; end
      S6: begin sensor = Tbl; is_green = 1'b1; end
      default: ;
    endcase
  end

  // Exit decision: greens leave on no demand after the minimum or at the hard maximum.
  always_comb begin
    if (is_green)
      phase_exit = ((tmr >= MIN_LAST) && !sensor) || (tmr == MAX_LAST);
    else
      phase_exit = (tmr == YEL_LAST);
  end

  // Successor phase; left phases are skipped when no left demand at the yellow exit.
  always_comb begin
    nxt = S0;
    case (state)
      S0: nxt = S1;
      S1: nxt = Tal ? S2 : S4;
      S2: nxt = S3;
      S3: nxt = S4;
      S4: nxt = S5;
      S5: nxt = Tbl ? S6 : S0;
      S6: nxt = S7;
      S7: nxt = S0;
      default: nxt = S0;
    endcase
  end

  // State and phase_start registers; en low freezes both.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S0;
      phase_start <= 1'b1;
    end else if (en) begin
      if (phase_exit) begin
        state       <= nxt;
        phase_start <= 1'b1;
      end else begin
        phase_start <= 1'b0;
      end
    end
  end

  assign lamps = lamp_decode(state);
  assign La    = lamps.la;
  assign Lb    = lamps.lb;
  assign q     = state;

endmodule
